block_data_memory: RTL and testbench

BLOCK_DATA_MEMORY -- requirements
Module: block_data_memory

---
 rtl/dmem_pkg.sv | 26 ++
 rtl/dmem_block_array.sv | 45 ++++
 rtl/block_data_memory.sv | 159 +++++++++++++++
 tb/tb_block_data_memory.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg
// Shared types and default sizing for the block data memory.
//   state_e : controller states (IDLE -> BUSY -> COMPLETE -> IDLE)
//   op_e    : operation latched when a request is accepted
//   DMEM_*  : default parameter values used by block_data_memory
// ---------------------------------------------------------------------------
package dmem_pkg;

    localparam int DMEM_BLOCK_BYTES = 16;
    localparam int DMEM_ADDR_W      = 28;
    localparam int DMEM_DEPTH       = 64;
    localparam int DMEM_LATENCY     = 5;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY     = 2'd1,
        COMPLETE = 2'd2
    } state_e;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

endpackage

// File: rtl/dmem_block_array.sv
// ---------------------------------------------------------------------------
// dmem_block_array
// DEPTH blocks of BLOCK_BYTES bytes. The whole block at ridx_i is always
// presented on rdata_o so the controller can capture it in a single edge;
// writes update only the byte lanes enabled in be_i, all in the same edge.
// The array has no reset: contents survive a controller reset.
//   clock   : write clock
//   we_i    : commit the write on this edge
//   widx_i  : block index written
//   wdata_i : write block, byte i at bits [8i+7:8i]
//   be_i    : per-byte write enable
//   ridx_i  : block index read
//   rdata_o : block currently stored at ridx_i
// ---------------------------------------------------------------------------
module dmem_block_array #(
    parameter int BLOCK_BYTES = 16,
    parameter int DEPTH       = 64,
    parameter int IDX_W       = 6
) (
    input  logic                     clock,
    input  logic                     we_i,
    input  logic [IDX_W-1:0]         widx_i,
    input  logic [8*BLOCK_BYTES-1:0] wdata_i,
    input  logic [BLOCK_BYTES-1:0]   be_i,
    input  logic [IDX_W-1:0]         ridx_i,
    output logic [8*BLOCK_BYTES-1:0] rdata_o
);

    logic [8*BLOCK_BYTES-1:0] mem_q [DEPTH];

    // Byte-lane write: every enabled lane lands on the same edge, so a
    // reader never sees a partially written block.
    always_ff @(posedge clock) begin
        if (we_i) begin
            for (int i = 0; i < BLOCK_BYTES; i++) begin
                if (be_i[i]) begin
                    mem_q[widx_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/block_data_memory.sv
// ---------------------------------------------------------------------------
// block_data_memory
// Multi-cycle block memory with a busywait handshake. A request is latched
// on acceptance, the controller stays BUSY for LATENCY cycles, commits the
// access on the last BUSY edge and then spends one COMPLETE cycle pulsing
// done (and error for illegal or out-of-range requests).
//   clock     : single clock, rising edge
//   reset_n   : asynchronous active-low reset
//   read      : block read request (level)
//   write     : block write request (level)
//   address   : block address
//   writedata : write block, byte i at bits [8i+7:8i]
//   byteen    : per-byte write enable
//   readdata  : registered read block, held until the next read commit
//   busywait  : access in progress, requester holds its inputs
//   done      : one-cycle completion pulse
//   error     : one-cycle bad-request pulse, coincident with done
// ---------------------------------------------------------------------------
module block_data_memory
    import dmem_pkg::*;
#(
    parameter int BLOCK_BYTES = DMEM_BLOCK_BYTES,
    parameter int ADDR_W      = DMEM_ADDR_W,
    parameter int DEPTH       = DMEM_DEPTH,
    parameter int LATENCY     = DMEM_LATENCY
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     read,
    input  logic                     write,
    input  logic [ADDR_W-1:0]        address,
    input  logic [8*BLOCK_BYTES-1:0] writedata,
    input  logic [BLOCK_BYTES-1:0]   byteen,
    output logic [8*BLOCK_BYTES-1:0] readdata,
    output logic                     busywait,
    output logic                     done,
    output logic                     error
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int DW    = 8 * BLOCK_BYTES;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    op_e                    op_q, op_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [DW-1:0]          wdata_q, wdata_d;
    logic [BLOCK_BYTES-1:0] be_q, be_d;
    logic [DW-1:0]          rdata_q, rdata_d;
    logic                   err_q, err_d;

    logic                   inRange;
    logic                   commit;
    logic                   memWe;
    logic [IDX_W-1:0]       blockIdx;
    logic [DW-1:0]          arrayRdata;

    // Out-of-range addresses are detected, never wrapped onto a real block.
    assign inRange  = (64'(addr_q) < 64'(DEPTH));
    assign blockIdx = addr_q[IDX_W-1:0];
    assign commit   = (state_q == BUSY) && (cnt_q == '0);
    assign memWe    = commit && (op_q == OP_WRITE) && inRange;

    dmem_block_array #(
        .BLOCK_BYTES (BLOCK_BYTES),
        .DEPTH       (DEPTH),
        .IDX_W       (IDX_W)
    ) u_array (
        .clock   (clock),
        .we_i    (memWe),
        .widx_i  (blockIdx),
        .wdata_i (wdata_q),
        .be_i    (be_q),
        .ridx_i  (blockIdx),
        .rdata_o (arrayRdata)
    );

    // Next-state logic. Request inputs are sampled only in IDLE, so anything
    // the requester does during BUSY or COMPLETE is ignored. COMPLETE always
    // returns to IDLE, which keeps a held request from being re-accepted in
    // the same cycle that signals done.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (read && write) begin
                    state_d = COMPLETE;
                    err_d   = 1'b1;
                end else if (read || write) begin
                    state_d = BUSY;
                    op_d    = write ? OP_WRITE : OP_READ;
                    addr_d  = address;
                    wdata_d = writedata;
                    be_d    = byteen;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    err_d   = 1'b0;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = COMPLETE;
                    err_d   = !inRange;
                    if (op_q == OP_READ) begin
                        rdata_d = inRange ? arrayRdata : '0;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            COMPLETE: begin
                state_d = IDLE;
                err_d   = 1'b0;
            end
            default: begin
                state_d = IDLE;
                err_d   = 1'b0;
            end
        endcase
    end

    // Controller registers. Reset abandons any access in flight; because the
    // array write is gated by the BUSY state, no partial write can escape.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= OP_READ;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign readdata = rdata_q;
    assign done     = (state_q == COMPLETE);
    assign error    = (state_q == COMPLETE) && err_q;
    assign busywait = ((state_q == IDLE) && (read || write)) || (state_q == BUSY);

endmodule

// File: tb/tb_block_data_memory.sv
// ---------------------------------------------------------------------------
// tb_block_data_memory
// Self-checking bench for block_data_memory with default parameters.
// Expected results are pushed to a scoreboard queue when a request is driven
// and popped by a monitor whenever the DUT pulses done.
// ---------------------------------------------------------------------------
module tb_block_data_memory;

    localparam int BB      = 16;
    localparam int DW      = 8 * BB;
    localparam int AW      = 28;
    localparam int DEPTH   = 64;
    localparam int LATENCY = 5;
    localparam int MAXWAIT = 50;

    logic          clock;
    logic          reset_n;
    logic          read;
    logic          write;
    logic [AW-1:0] address;
    logic [DW-1:0] writedata;
    logic [BB-1:0] byteen;
    logic [DW-1:0] readdata;
    logic          busywait;
    logic          done;
    logic          error;

    typedef struct {
        logic [DW-1:0] rd;
        logic          err;
    } exp_t;

    typedef struct {
        logic          rd;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [BB-1:0] be;
        logic          useExp;
        logic [DW-1:0] expRd;
        logic          expErr;
        int            expBusy;
    } vec_t;

    exp_t          scoreQ[$];
    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] lastRd;
    int            checkCount = 0;
    int            passCount  = 0;
    int            doneCount  = 0;
    int            pushCount  = 0;

    block_data_memory #(
        .BLOCK_BYTES (BB),
        .ADDR_W      (AW),
        .DEPTH       (DEPTH),
        .LATENCY     (LATENCY)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .read      (read),
        .write     (write),
        .address   (address),
        .writedata (writedata),
        .byteen    (byteen),
        .readdata  (readdata),
        .busywait  (busywait),
        .done      (done),
        .error     (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (reset_n && done) begin
            doneCount++;
            if (scoreQ.size() == 0) begin
                checkOutput("unexpected_done", 128'd1, 128'd0);
            end else begin
                exp_t e;
                e = scoreQ.pop_front();
                checkOutput("sb_readdata", readdata, e.rd);
                checkOutput("sb_error", {127'd0, error}, {127'd0, e.err});
            end
        end
    end

    // Reference behaviour: updates the shadow memory and the held readdata.
    task automatic modelExpect(input logic rd, input logic wr, input logic [AW-1:0] addr,
                               input logic [DW-1:0] data, input logic [BB-1:0] be,
                               output logic [DW-1:0] er, output logic ee);
        if (rd && wr) begin
            er = lastRd;
            ee = 1'b1;
        end else if (addr >= AW'(DEPTH)) begin
            ee = 1'b1;
            if (rd) lastRd = '0;
            er = lastRd;
        end else begin
            ee = 1'b0;
            if (rd) begin
                lastRd = model[addr[5:0]];
            end else begin
                for (int i = 0; i < BB; i++) begin
                    if (be[i]) model[addr[5:0]][8*i +: 8] = data[8*i +: 8];
                end
            end
            er = lastRd;
        end
    endtask

    task automatic waitDone(input int startCycles, output int cycles, output bit ok);
        cycles = startCycles;
        ok     = 1'b0;
        for (int n = 0; n < MAXWAIT; n++) begin
            @(negedge clock);
            if (done) begin
                ok = 1'b1;
                break;
            end
            if (busywait) cycles++;
        end
        if (!ok) checkOutput("done_timeout", 128'd0, 128'd1);
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] data, input logic [BB-1:0] be,
                                 input logic [DW-1:0] expRd, input logic expErr,
                                 input int expBusy, input bit hold);
        exp_t e;
        int   cycles;
        bit   ok;
        @(negedge clock);
        read      = rd;
        write     = wr;
        address   = addr;
        writedata = data;
        byteen    = be;
        e.rd      = expRd;
        e.err     = expErr;
        scoreQ.push_back(e);
        pushCount++;
        #1;
        checkOutput("busywait_on_request", {127'd0, busywait}, 128'd1);
        waitDone(1, cycles, ok);
        if (ok) begin
            checkOutput("busy_cycles", 128'(cycles), 128'(expBusy));
            checkOutput("busywait_in_complete", {127'd0, busywait}, 128'd0);
        end
        if (!hold) begin
            read  = 1'b0;
            write = 1'b0;
        end
    endtask

    initial begin
        vec_t          vecs[10];
        logic [DW-1:0] blockA;
        logic [DW-1:0] blockAff;
        logic [DW-1:0] er;
        logic          ee;
        logic [DW-1:0] rnd;
        logic [BB-1:0] rbe;
        int            cycles;
        bit            ok;
        exp_t          e;

        blockA   = 128'h0F0E0D0C0B0A09080706050403020100;
        blockAff = 128'h0F0E0D0C0B0A090807060504030201FF;
        //           rd    wr    addr          data         be       useExp expRd     expErr busy
        vecs[0] = '{1'b0, 1'b1, 28'd3,        blockA,      16'hFFFF, 1'b0, '0,       1'b0, 6};
        vecs[1] = '{1'b1, 1'b0, 28'd3,        '0,          16'h0000, 1'b1, blockA,   1'b0, 6};
        vecs[2] = '{1'b0, 1'b1, 28'd3,        {DW{1'b1}},  16'h0001, 1'b1, blockA,   1'b0, 6};
        vecs[3] = '{1'b1, 1'b0, 28'd3,        '0,          16'h0000, 1'b1, blockAff, 1'b0, 6};
        vecs[4] = '{1'b1, 1'b0, 28'd64,       '0,          16'h0000, 1'b1, '0,       1'b1, 6};
        vecs[5] = '{1'b0, 1'b1, 28'd64,       {DW{1'b1}},  16'hFFFF, 1'b1, '0,       1'b1, 6};
        vecs[6] = '{1'b1, 1'b0, 28'd3,        '0,          16'h0000, 1'b1, blockAff, 1'b0, 6};
        vecs[7] = '{1'b0, 1'b1, 28'hFFFFFFF,  '0,          16'hFFFF, 1'b1, blockAff, 1'b1, 6};
        vecs[8] = '{1'b1, 1'b1, 28'd3,        '0,          16'hFFFF, 1'b1, blockAff, 1'b1, 1};
        vecs[9] = '{1'b1, 1'b0, 28'd3,        '0,          16'h0000, 1'b1, blockAff, 1'b0, 6};

        reset_n   = 1'b0;
        read      = 1'b0;
        write     = 1'b0;
        address   = '0;
        writedata = '0;
        byteen    = '0;
        lastRd    = '0;

        // Reset state
        repeat (2) @(negedge clock);
        checkOutput("reset_readdata", readdata, '0);
        checkOutput("reset_done", {127'd0, done}, 128'd0);
        checkOutput("reset_error", {127'd0, error}, 128'd0);
        checkOutput("reset_busywait", {127'd0, busywait}, 128'd0);
        reset_n = 1'b1;

        // Bring every block to a known value
        for (int b = 0; b < DEPTH; b++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom};
            modelExpect(1'b0, 1'b1, AW'(b), rnd, {BB{1'b1}}, er, ee);
            applyStimulus(1'b0, 1'b1, AW'(b), rnd, {BB{1'b1}}, er, ee, LATENCY + 1, 1'b0);
        end

        // Directed vectors: read/write, byte enable, out of range, illegal
        for (int v = 0; v < 10; v++) begin
            modelExpect(vecs[v].rd, vecs[v].wr, vecs[v].addr, vecs[v].data, vecs[v].be, er, ee);
            if (vecs[v].useExp) begin
                er = vecs[v].expRd;
                if (vecs[v].rd && !vecs[v].wr) lastRd = er;
            end
            applyStimulus(vecs[v].rd, vecs[v].wr, vecs[v].addr, vecs[v].data, vecs[v].be,
                          er, vecs[v].expErr, vecs[v].expBusy, 1'b0);
        end

        // Held read: one done per acceptance, re-acceptance only from IDLE
        modelExpect(1'b1, 1'b0, 28'd5, '0, '0, er, ee);
        applyStimulus(1'b1, 1'b0, 28'd5, '0, '0, er, ee, LATENCY + 1, 1'b1);
        modelExpect(1'b1, 1'b0, 28'd5, '0, '0, er, ee);
        e.rd  = er;
        e.err = ee;
        scoreQ.push_back(e);
        pushCount++;
        @(negedge clock);
        checkOutput("held_idle_done", {127'd0, done}, 128'd0);
        checkOutput("held_idle_busywait", {127'd0, busywait}, 128'd1);
        @(negedge clock);
        read = 1'b0;
        checkOutput("held_second_busy", {127'd0, busywait}, 128'd1);
        waitDone(2, cycles, ok);
        if (ok) checkOutput("held_busy_cycles", 128'(cycles), 128'(LATENCY + 1));

        // Reset in the third BUSY cycle of a write to block 7
        @(negedge clock);
        write     = 1'b1;
        address   = 28'd7;
        writedata = {DW{1'b1}} ^ model[7];
        byteen    = {BB{1'b1}};
        repeat (3) @(negedge clock);
        reset_n = 1'b0;
        write   = 1'b0;
        #1;
        checkOutput("abort_readdata", readdata, '0);
        checkOutput("abort_done", {127'd0, done}, 128'd0);
        checkOutput("abort_error", {127'd0, error}, 128'd0);
        checkOutput("abort_busywait", {127'd0, busywait}, 128'd0);
        @(negedge clock);
        reset_n = 1'b1;
        lastRd  = '0;
        modelExpect(1'b1, 1'b0, 28'd7, '0, '0, er, ee);
        applyStimulus(1'b1, 1'b0, 28'd7, '0, '0, er, ee, LATENCY + 1, 1'b0);

        // Back-to-back random write/read over every block
        for (int b = 0; b < DEPTH; b++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom};
            rbe = BB'($urandom);
            modelExpect(1'b0, 1'b1, AW'(b), rnd, rbe, er, ee);
            applyStimulus(1'b0, 1'b1, AW'(b), rnd, rbe, er, ee, LATENCY + 1, 1'b0);
            modelExpect(1'b1, 1'b0, AW'(b), '0, '0, er, ee);
            applyStimulus(1'b1, 1'b0, AW'(b), '0, '0, er, ee, LATENCY + 1, 1'b0);
        end

        repeat (3) @(negedge clock);
        checkOutput("done_count", 128'(doneCount), 128'(pushCount));
        checkOutput("scoreboard_empty", 128'(scoreQ.size()), 128'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
